// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle CPU controller and its datapath.
// The controller (master) receives the IR opcode and the memory handshake and
// drives every datapath select/enable plus a debug view of its state.
interface multicycle_control_fsm_if;

   logic [5:0] opcode;
   logic       mem_ready;

   logic       IorD;
   logic       IRWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSrc;
   logic       PCWrite;
   logic       Branch;
   logic       instr_done;
   logic       illegal;
   logic [3:0] state;

   // Controller side
   modport master (
      input  opcode, mem_ready,
      output IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
             ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch,
             instr_done, illegal, state
   );

   // Datapath side
   modport slave (
      output opcode, mem_ready,
      input  IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
             ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch,
             instr_done, illegal, state
   );

endinterface

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multi-cycle CPU.
// Moore FSM stepping each instruction through fetch, decode, execute, memory
// and writeback. The state-decoded controls are registered alongside the
// state itself; only the mem_ready-dependent enables, the illegal-opcode flag
// and the reset kill of the write enables are formed combinationally.
module multicycle_control_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input logic                    clk,
   input logic                    reset,
   multicycle_control_fsm_if.master bus
);

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMRD    = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWR    = 4'd5,
      ST_EXECUTE  = 4'd6,
      ST_ALUWB    = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_ADDIEXEC = 4'd9,
      ST_ADDIWB   = 4'd10,
      ST_JUMP     = 4'd11
   } state_t;

   // Registered control word. The fetch/decode/memwr flags mark the states
   // whose enables also depend on live inputs (mem_ready or the opcode).
   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       pc_write;
      logic       branch;
      logic       done;
      logic       in_fetch;
      logic       in_decode;
      logic       in_memwr;
   } ctrl_t;

   state_t cur_state;
   state_t next_state;
   ctrl_t  ctrl_q;
   logic   op_known;

   // Control word for a given state; unlisted fields and unused encodings are 0
   function automatic ctrl_t decode_state(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH: begin
            c.iord      = 1'b0;
            c.alu_src_a = 1'b0;
            c.alu_src_b = 2'b01;
            c.alu_op    = 2'b00;
            c.pc_src    = 2'b00;
            c.in_fetch  = 1'b1;
         end
         ST_DECODE: begin
            c.alu_src_a = 1'b0;
            c.alu_src_b = 2'b11;
            c.alu_op    = 2'b00;
            c.in_decode = 1'b1;
         end
         ST_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_op    = 2'b00;
         end
         ST_MEMRD: begin
            c.iord = 1'b1;
         end
         ST_MEMWB: begin
            c.reg_dst    = 1'b0;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.done       = 1'b1;
         end
         ST_MEMWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
            c.in_memwr  = 1'b1;
         end
         ST_EXECUTE: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b00;
            c.alu_op    = 2'b10;
         end
         ST_ALUWB: begin
            c.reg_dst    = 1'b1;
            c.mem_to_reg = 1'b0;
            c.reg_write  = 1'b1;
            c.done       = 1'b1;
         end
         ST_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b00;
            c.alu_op    = 2'b01;
            c.pc_src    = 2'b01;
            c.branch    = 1'b1;
            c.done      = 1'b1;
         end
         ST_ADDIEXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_op    = 2'b00;
         end
         ST_ADDIWB: begin
            c.reg_dst    = 1'b0;
            c.mem_to_reg = 1'b0;
            c.reg_write  = 1'b1;
            c.done       = 1'b1;
         end
         ST_JUMP: begin
            c.pc_src   = 2'b10;
            c.pc_write = 1'b1;
            c.done     = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Recognise the opcodes this controller knows how to sequence
   always_comb begin
      op_known = 1'b0;
      case (bus.opcode)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
         default:                                       op_known = 1'b0;
      endcase
   end

   // Next-state selection; opcode is only consulted in DECODE and MEMADR
   always_comb begin
      next_state = ST_FETCH;
      case (cur_state)
         ST_FETCH:    next_state = bus.mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            if (bus.opcode == OP_LW || bus.opcode == OP_SW) next_state = ST_MEMADR;
            else if (bus.opcode == OP_RTYPE)                next_state = ST_EXECUTE;
            else if (bus.opcode == OP_BEQ)                  next_state = ST_BRANCH;
            else if (bus.opcode == OP_ADDI)                 next_state = ST_ADDIEXEC;
            else if (bus.opcode == OP_J)                    next_state = ST_JUMP;
            else                                            next_state = ST_FETCH;
         end
         ST_MEMADR:   next_state = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:    next_state = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
         ST_MEMWB:    next_state = ST_FETCH;
         ST_MEMWR:    next_state = bus.mem_ready ? ST_FETCH : ST_MEMWR;
         ST_EXECUTE:  next_state = ST_ALUWB;
         ST_ALUWB:    next_state = ST_FETCH;
         ST_BRANCH:   next_state = ST_FETCH;
         ST_ADDIEXEC: next_state = ST_ADDIWB;
         ST_ADDIWB:   next_state = ST_FETCH;
         ST_JUMP:     next_state = ST_FETCH;
         default:     next_state = ST_FETCH;
      endcase
   end

   // State register with its control word loaded in lockstep
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= ST_FETCH;
         ctrl_q    <= decode_state(ST_FETCH);
      end else begin
         cur_state <= next_state;
         ctrl_q    <= decode_state(next_state);
      end
   end

   assign bus.IorD     = ctrl_q.iord;
   assign bus.RegDst   = ctrl_q.reg_dst;
   assign bus.MemtoReg = ctrl_q.mem_to_reg;
   assign bus.ALUSrcA  = ctrl_q.alu_src_a;
   assign bus.ALUSrcB  = ctrl_q.alu_src_b;
   assign bus.ALUOp    = ctrl_q.alu_op;
   assign bus.PCSrc    = ctrl_q.pc_src;
   assign bus.state    = cur_state;

   assign bus.IRWrite    = ~reset & ctrl_q.in_fetch & bus.mem_ready;
   assign bus.PCWrite    = ~reset & (ctrl_q.pc_write | (ctrl_q.in_fetch & bus.mem_ready));
   assign bus.MemWrite   = ~reset & ctrl_q.mem_write;
   assign bus.RegWrite   = ~reset & ctrl_q.reg_write;
   assign bus.Branch     = ~reset & ctrl_q.branch;
   assign bus.illegal    = ~reset & ctrl_q.in_decode & ~op_known;
   assign bus.instr_done = ~reset & (ctrl_q.done
                                     | (ctrl_q.in_memwr & bus.mem_ready)
                                     | (ctrl_q.in_decode & ~op_known));

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main controller for the multi-cycle CPU.
- Sequences instruction fetch, decode, execute, memory and writeback over several cycles. Drives the 32x32 register file write enable (RegWrite) and its write-address/data select, plus the ALU operand muxes, memory and PC enables.
- Moore FSM. All control outputs are decoded from the current state, except the mem_ready gating and the illegal-opcode flag.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_ADDI, 6'b001000, add immediate
- OP_J, 6'b000010, jump

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- opcode  input  6  instr[31:26] from the instruction register
- mem_ready  input  1  memory access completes this cycle
- IorD  output  1  memory address: 0=PC, 1=ALUOut
- IRWrite  output  1  load instruction register
- MemWrite  output  1  memory write enable
- RegWrite  output  1  register-file write enable
- RegDst  output  1  register write address: 0=rt, 1=rd
- MemtoReg  output  1  register write data: 0=ALUOut, 1=MDR
- ALUSrcA  output  1  0=PC, 1=register A
- ALUSrcB  output  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
- ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
- PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- PCWrite  output  1  unconditional PC load
- Branch  output  1  conditional PC load; the datapath ANDs it with Zero
- instr_done  output  1  last cycle of the current instruction
- illegal  output  1  unrecognised opcode seen in DECODE
- state  output  4  current state encoding, for debug

Behaviour:
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- Encodings 12-15 go to FETCH on the next edge. All their outputs are 0.
- Reset: when reset=1 at a clk edge, state becomes FETCH.
- While reset=1, IRWrite, PCWrite, MemWrite, RegWrite, Branch, instr_done and illegal are forced to 0 combinationally.
- Any unlisted output is 0 in a given state.
- Outputs and transitions per state:
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Branch on opcode:
    - LW or SW -> MEMADR
    - RTYPE -> EXECUTE
    - BEQ -> BRANCH
    - ADDI -> ADDIEXEC
    - J -> JUMP
    - anything else -> FETCH, with illegal=1 and instr_done=1 in this cycle
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if opcode=LW, else MEMWR.
  - MEMRD: IorD=1. Stay while mem_ready=0; go to MEMWB when mem_ready=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Go to FETCH.
  - MEMWR: IorD=1, MemWrite=1 held for every cycle in this state. instr_done=mem_ready. Go to FETCH when mem_ready=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, instr_done=1. Go to FETCH.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Go to FETCH.
  - JUMP: PCSrc=10, PCWrite=1, instr_done=1. Go to FETCH.
- Latency with mem_ready held at 1: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3 cycles.
- Each extra mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- The opcode is sampled only in DECODE and MEMADR. The IR is stable there because IRWrite is 0 outside FETCH.
- RegWrite is high in exactly one cycle per lw, R-type or addi, and never for sw, beq, j or illegal opcodes.
- Reset asserted mid-instruction, including during a MEMWR wait: the write enables drop in the same cycle, and the next state is FETCH.

Test Plan:
- Reset held 2 cycles, then released, mem_ready=1: state=0 and all enables 0 during reset. The first cycle after release has IRWrite=PCWrite=1.
- lw (opcode 100011), mem_ready=1: states 0,1,2,3,4. RegWrite=1 with MemtoReg=1 and RegDst=0 only in the 5th cycle. instr_done on cycle 5.
- R-type then addi back-to-back: states 0,1,6,7 then 0,1,9,10. RegDst=1 in ALUWB, RegDst=0 in ADDIWB. Exactly 2 RegWrite pulses over 8 cycles.
- sw with mem_ready=0 for 3 cycles in MEMWR: MemWrite high for 4 consecutive cycles, RegWrite never high, instr_done only on the mem_ready=1 cycle.
- beq and j: beq gives 3 cycles with Branch=1, ALUOp=01, PCSrc=01 in state 8. j gives PCWrite=1, PCSrc=10 in state 11.
- Illegal opcode 111111: illegal=1 and instr_done=1 in DECODE, next state FETCH, no RegWrite/MemWrite. Also, reset asserted during a MEMRD wait leads to FETCH on the next edge.
